// File: rtl/tick_gen_multi_pkg.sv
// rtl/tick_gen_multi_pkg.sv - shared timebase constants and channel index assignment
// Contents:
//   DIV_*        default divisors for a 100 MHz clock
//   ch_idx_e     channel index assignment, used by consumers to select tick bits
package tick_gen_multi_pkg;

   localparam int unsigned DIV_1HZ   = 100000000;
   localparam int unsigned DIV_2HZ   = 50000000;
   localparam int unsigned DIV_380HZ = 262144;
   localparam int unsigned DIV_5HZ   = 20000000;

   typedef enum logic [1:0] {
      CH_1HZ = 2'd0,
      CH_2HZ = 2'd1,
      CH_SEG = 2'd2,
      CH_ADJ = 2'd3
   } ch_idx_e;

endpackage

// File: rtl/tick_gen_multi_chan.sv
// rtl/tick_gen_multi_chan.sv - one timebase channel: counter, divisor, tick and toggle
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   en, clr      count enable (pause when 0), phase clear (dominates en)
//   wr_en        already-decoded divisor write strobe for this channel
//   wr_div       new divisor value
//   tick         registered one-cycle pulse on wrap
//   sq           registered toggle, flips on every tick
//   cnt          live counter value
module tick_chan
   import tick_gen_multi_pkg::*;
#(
   parameter int              CW      = 27,
   parameter logic [CW-1:0]   DIV_RST = CW'(DIV_1HZ)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [CW-1:0] wr_div,
   output logic          tick,
   output logic          sq,
   output logic [CW-1:0] cnt
);

   logic [CW-1:0] r_div;
   logic [CW-1:0] r_cnt;
   logic          r_tick;
   logic          r_sq;
   logic [CW-1:0] w_last;
   logic          w_wrap;

   // Divisors 0 and 1 both mean "tick every enabled cycle".
   assign w_last = (r_div < CW'(2)) ? '0 : r_div - CW'(1);
   // >= rather than == so a divisor shrunk below the live count wraps at once.
   assign w_wrap = (r_cnt >= w_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div  <= DIV_RST;
         r_cnt  <= '0;
         r_tick <= 1'b0;
         r_sq   <= 1'b0;
      end else begin
         // The wrap below reads the old r_div, so a write lands after it.
         if (wr_en) begin
            r_div <= wr_div;
         end
         if (clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
         end else if (!en) begin
            r_tick <= 1'b0;
         end else if (w_wrap) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            r_sq   <= ~r_sq;
         end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
         end
      end
   end

   assign tick = r_tick;
   assign sq   = r_sq;
   assign cnt  = r_cnt;

endmodule

// File: rtl/tick_gen_multi.sv
// rtl/tick_gen_multi.sv - parametrised multi-channel timebase generator
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   en           count enable for all channels (0 = pause)
//   clr          phase clear of all counters; divisors kept
//   wr_en/wr_ch/wr_div  runtime divisor write; out-of-range channel ignored
//   tick[NCH]    one-cycle wrap pulse per channel
//   sq[NCH]      per-channel toggle at half the tick rate
//   cnt          live counters, channel i at cnt[i*CW +: CW]
module tick_gen_multi
   import tick_gen_multi_pkg::*;
#(
   parameter int                  NCH  = 4,
   parameter int                  CW   = 27,
   parameter logic [NCH*CW-1:0]   DIVS = {CW'(DIV_5HZ), CW'(DIV_380HZ), CW'(DIV_2HZ), CW'(DIV_1HZ)},
   parameter int                  CHW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [CHW-1:0]    wr_ch,
   input  logic [CW-1:0]     wr_div,
   output logic [NCH-1:0]    tick,
   output logic [NCH-1:0]    sq,
   output logic [NCH*CW-1:0] cnt
);

   logic [NCH-1:0] w_wr;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      // Indices >= NCH match no channel, so such writes fall away.
      assign w_wr[i] = wr_en && (wr_ch == CHW'(i));

      tick_chan #(
         .CW      (CW),
         .DIV_RST (DIVS[i*CW +: CW])
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .en     (en),
         .clr    (clr),
         .wr_en  (w_wr[i]),
         .wr_div (wr_div),
         .tick   (tick[i]),
         .sq     (sq[i]),
         .cnt    (cnt[i*CW +: CW])
      );
   end

endmodule
